// File: rtl/result_drain_writer_pkg.sv
// rtl/result_drain_writer_pkg.sv - shared types and helpers for the result drain writer
package result_drain_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } drain_state_t;

  // Default geometry of the C matrix.
  localparam int DEF_A_ROWS = 2;
  localparam int DEF_B_COLS = 2;
  localparam int DEF_N      = DEF_A_ROWS * DEF_B_COLS;

  function automatic int elem_count(input int rows, input int cols);
    return rows * cols;
  endfunction

  // Address width for n elements, never narrower than one bit.
  function automatic int addr_bits(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Narrowing rule: zero-extend when widening, otherwise clamp or keep low bits.
  function automatic logic [63:0] sat_fmt(input logic [63:0] x, input int in_w,
                                          input int out_w, input int saturate);
    logic [63:0] lim;
    if (out_w >= in_w) return x;
    lim = (64'd1 << out_w) - 64'd1;
    if (saturate != 0 && x > lim) return lim;
    return x & lim;
  endfunction

endpackage

// File: rtl/result_drain_writer_if.sv
// rtl/result_drain_writer_if.sv - valid/ready write stream toward matrix C memory
interface result_drain_writer_if #(
  parameter int ADDR_W    = 2,
  parameter int OUT_WIDTH = 16
);
  logic                 out_valid;
  logic                 out_ready;
  logic [ADDR_W-1:0]    out_addr;
  logic [OUT_WIDTH-1:0] out_data;
  logic                 out_last;

  modport master (output out_valid, out_addr, out_data, out_last, input out_ready);
  modport slave  (input out_valid, out_addr, out_data, out_last, output out_ready);
endinterface

// File: rtl/result_drain_writer_c_elem_format.sv
// rtl/result_drain_writer_c_elem_format.sv - combinational element width formatter
module c_elem_format
  import result_drain_pkg::*;
#(
  parameter int IN_W     = 16,
  parameter int OUT_W    = 16,
  parameter int SATURATE = 1
) (
  input  logic [IN_W-1:0]  x,
  output logic [OUT_W-1:0] y
);

  // Apply the shared narrowing rule and cut the result to the output width.
  always_comb begin
    y = OUT_W'(sat_fmt(64'(x), IN_W, OUT_W, SATURATE));
  end

endmodule

// File: rtl/result_drain_writer.sv
// rtl/result_drain_writer.sv - snapshot matrix C and drain it row-major over a write stream
module result_drain_writer
  import result_drain_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int A_ROWS     = DEF_A_ROWS,
  parameter int B_COLS     = DEF_B_COLS,
  parameter int OUT_WIDTH  = 2 * DATA_WIDTH,
  parameter int SATURATE   = 1,
  parameter int ADDR_W     = addr_bits(elem_count(A_ROWS, B_COLS))
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [2*DATA_WIDTH-1:0] result [0:A_ROWS-1][0:B_COLS-1],
  result_drain_writer_if.master   wr,
  output logic                    busy,
  output logic                    done
);

  localparam int N  = elem_count(A_ROWS, B_COLS);
  localparam int EW = 2 * DATA_WIDTH;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N - 1);

  drain_state_t         state;
  logic [ADDR_W-1:0]    index;
  logic [ADDR_W-1:0]    next_index;
  logic [EW-1:0]        snapshot [N];
  logic [EW-1:0]        fmt_in;
  logic [OUT_WIDTH-1:0] fmt_out;
  logic                 xfer;

  assign xfer       = wr.out_valid && wr.out_ready;
  assign next_index = index + ADDR_W'(1);

  // Formatter source: live element 0 at capture, otherwise the element after the current beat.
  always_comb begin
    fmt_in = snapshot[0];
    if (state == IDLE) begin
      fmt_in = result[0][0];
    end else if (index != LAST_IDX) begin
      fmt_in = snapshot[next_index];
    end
  end

  c_elem_format #(
    .IN_W    (EW),
    .OUT_W   (OUT_WIDTH),
    .SATURATE(SATURATE)
  ) u_fmt (
    .x(fmt_in),
    .y(fmt_out)
  );

  // Drain FSM; beat outputs are registered one step ahead so they hold while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      index        <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      wr.out_valid <= 1'b0;
      wr.out_addr  <= '0;
      wr.out_data  <= '0;
      wr.out_last  <= 1'b0;
      for (int k = 0; k < N; k++) snapshot[k] <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            for (int i = 0; i < A_ROWS; i++)
              for (int j = 0; j < B_COLS; j++)
                snapshot[i*B_COLS+j] <= result[i][j];
            index        <= '0;
            state        <= DRAIN;
            busy         <= 1'b1;
            wr.out_valid <= 1'b1;
            wr.out_addr  <= '0;
            wr.out_data  <= fmt_out;
            wr.out_last  <= (LAST_IDX == '0);
          end
        end
        DRAIN: begin
          if (xfer) begin
            if (index == LAST_IDX) begin
              state        <= DONE;
              index        <= '0;
              done         <= 1'b1;
              wr.out_valid <= 1'b0;
              wr.out_addr  <= '0;
              wr.out_data  <= '0;
              wr.out_last  <= 1'b0;
            end else begin
              index       <= next_index;
              wr.out_addr <= next_index;
              wr.out_data <= fmt_out;
              wr.out_last <= (next_index == LAST_IDX);
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_result_drain_writer.sv
// tb/tb_result_drain_writer.sv - scoreboard bench for result_drain_writer
module tb_result_drain_writer;

  logic        clk;
  logic        reset;
  logic        start;
  logic        start1;
  logic        rdy;
  logic [15:0] res  [0:1][0:1];
  logic [15:0] res1 [0:0][0:0];
  logic [3:0]  busy;
  logic [3:0]  done;

  // dut0: 16-bit out; dut1: 8-bit saturating; dut2: 8-bit truncating; dut3: 1x1 matrix
  result_drain_writer_if #(.ADDR_W(2), .OUT_WIDTH(16)) if0 ();
  result_drain_writer_if #(.ADDR_W(2), .OUT_WIDTH(8))  if1 ();
  result_drain_writer_if #(.ADDR_W(2), .OUT_WIDTH(8))  if2 ();
  result_drain_writer_if #(.ADDR_W(1), .OUT_WIDTH(16)) if3 ();

  assign if0.out_ready = rdy;
  assign if1.out_ready = rdy;
  assign if2.out_ready = rdy;
  assign if3.out_ready = rdy;

  result_drain_writer #(.DATA_WIDTH(8), .A_ROWS(2), .B_COLS(2), .OUT_WIDTH(16), .SATURATE(1)) dut0 (
    .clk(clk), .reset(reset), .start(start), .result(res), .wr(if0), .busy(busy[0]), .done(done[0]));
  result_drain_writer #(.DATA_WIDTH(8), .A_ROWS(2), .B_COLS(2), .OUT_WIDTH(8), .SATURATE(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .result(res), .wr(if1), .busy(busy[1]), .done(done[1]));
  result_drain_writer #(.DATA_WIDTH(8), .A_ROWS(2), .B_COLS(2), .OUT_WIDTH(8), .SATURATE(0)) dut2 (
    .clk(clk), .reset(reset), .start(start), .result(res), .wr(if2), .busy(busy[2]), .done(done[2]));
  result_drain_writer #(.DATA_WIDTH(8), .A_ROWS(1), .B_COLS(1), .OUT_WIDTH(16), .SATURATE(1)) dut3 (
    .clk(clk), .reset(reset), .start(start1), .result(res1), .wr(if3), .busy(busy[3]), .done(done[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        mv [4];
  logic        ml [4];
  logic [7:0]  ma [4];
  logic [15:0] mdat [4];
  assign mv[0] = if0.out_valid; assign ml[0] = if0.out_last; assign ma[0] = 8'(if0.out_addr); assign mdat[0] = if0.out_data;
  assign mv[1] = if1.out_valid; assign ml[1] = if1.out_last; assign ma[1] = 8'(if1.out_addr); assign mdat[1] = 16'(if1.out_data);
  assign mv[2] = if2.out_valid; assign ml[2] = if2.out_last; assign ma[2] = 8'(if2.out_addr); assign mdat[2] = 16'(if2.out_data);
  assign mv[3] = if3.out_valid; assign ml[3] = if3.out_last; assign ma[3] = 8'(if3.out_addr); assign mdat[3] = if3.out_data;

  // expected beat = {last, addr[7:0], data[15:0]}
  logic [24:0] expq [4][$];
  int errors = 0;
  int checks = 0;
  int exp_blen = 0;
  int tmo_req = 0;
  int tmo_seen = 0;
  bit end_req = 0;
  bit end_ack = 0;

  // Reference formatting written straight from the arithmetic rule.
  function automatic logic [15:0] ref_fmt(input int x, input int ow, input int sat);
    int lim;
    if (ow >= 16) return 16'(x);
    lim = (1 << ow) - 1;
    if (sat != 0 && x > lim) return 16'(lim);
    return 16'(x % (lim + 1));
  endfunction

  task automatic push_exp();
    int ow [3] = '{16, 8, 8};
    int sat [3] = '{1, 1, 0};
    for (int k = 0; k < 3; k++)
      for (int idx = 0; idx < 4; idx++)
        expq[k].push_back({idx == 3, 8'(idx), ref_fmt(int'(res[idx/2][idx%2]), ow[k], sat[k])});
    expq[3].push_back({1'b1, 8'd0, res1[0][0]});
  endtask

  task automatic issue_start();
    push_exp();
    start = 1'b1;
    start1 = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic wait_idle(input bit rnd);
    int n = 0;
    forever begin
      @(posedge clk); #1;
      start = 1'b0;
      if (busy == 4'b0) begin rdy = 1'b1; break; end
      n++;
      if (n > 100) begin tmo_req++; rdy = 1'b1; break; end
      if (rnd) begin
        rdy = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 5) == 0) begin
          start = 1'b1;
          res[$urandom_range(0, 1)][$urandom_range(0, 1)] = 16'($urandom);
        end
      end
    end
  endtask

  function automatic logic [15:0] rnd_elem();
    return ($urandom_range(0, 1) != 0) ? 16'($urandom_range(0, 300)) : 16'($urandom);
  endfunction

  // Monitor: compares every presented beat with the scoreboard head, pops on transfer.
  bit rst_prev = 0;
  bit prev_lastx [4] = '{0, 0, 0, 0};
  int blen = 0;
  always @(negedge clk) begin
    bit post_reset;
    post_reset = rst_prev;
    rst_prev = reset;
    for (int k = 0; k < 4; k++) begin
      if (post_reset) begin
        checks++;
        if (mv[k] || ml[k] || ma[k] != 0 || mdat[k] != 0 || busy[k] || done[k]) begin
          errors++;
          $display("FAIL reset_out dut%0d got v=%0d l=%0d a=%0d d=%0d busy=%0d done=%0d exp all 0",
                   k, mv[k], ml[k], ma[k], mdat[k], busy[k], done[k]);
        end
      end else begin
        checks++;
        if (done[k] !== prev_lastx[k]) begin
          errors++;
          $display("FAIL done_pulse dut%0d got %0d exp %0d", k, done[k], prev_lastx[k]);
        end
        if (mv[k]) begin
          checks++;
          if (expq[k].size() == 0) begin
            errors++;
            $display("FAIL extra_beat dut%0d got addr=%0d data=%0d exp no beat", k, ma[k], mdat[k]);
          end else if ({ml[k], ma[k], mdat[k]} !== expq[k][0]) begin
            errors++;
            $display("FAIL beat dut%0d got last=%0d addr=%0d data=%0d exp last=%0d addr=%0d data=%0d",
                     k, ml[k], ma[k], mdat[k], expq[k][0][24], expq[k][0][23:16], expq[k][0][15:0]);
          end
          if (rdy && !reset && expq[k].size() != 0) void'(expq[k].pop_front());
        end
      end
      prev_lastx[k] = !reset && mv[k] && rdy && ml[k];
    end
    if (busy[0]) blen++;
    else if (blen != 0) begin
      if (exp_blen != 0 && !post_reset) begin
        checks++;
        if (blen != exp_blen) begin
          errors++;
          $display("FAIL busy_len got %0d exp %0d", blen, exp_blen);
        end
      end
      blen = 0;
    end
    if (reset) for (int k = 0; k < 4; k++) expq[k].delete();
    if (tmo_req != tmo_seen) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout got busy=%0b exp 0 within 100 cycles", busy);
      tmo_seen = tmo_req;
    end
    if (end_req && !end_ack) begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (expq[k].size() != 0) begin
          errors++;
          $display("FAIL lost_beats dut%0d got %0d pending exp 0", k, expq[k].size());
        end
      end
      end_ack = 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no finish exp finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; start1 = 1'b0; rdy = 1'b1;
    res = '{'{16'd0, 16'd0}, '{16'd0, 16'd0}};
    res1[0][0] = 16'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // basic drain, ready held high; 1x1 instance carries 7
    res = '{'{16'd19, 16'd22}, '{16'd43, 16'd50}};
    res1[0][0] = 16'd7;
    exp_blen = 5;
    issue_start();
    wait_idle(0);

    // stall three cycles while addr 1 is presented
    exp_blen = 0;
    issue_start();
    @(posedge clk); #1 rdy = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rdy = 1'b1;
    wait_idle(0);

    // width formatting: clamp vs keep-low-bits
    res = '{'{16'd300, 16'd200}, '{16'd255, 16'd256}};
    res1[0][0] = 16'd65535;
    issue_start();
    wait_idle(0);

    // new data and a start during drain must not disturb the snapshot
    res = '{'{16'd1, 16'd2}, '{16'd3, 16'd4}};
    exp_blen = 5;
    issue_start();
    res = '{'{16'd91, 16'd92}, '{16'd93, 16'd94}};
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_idle(0);

    // reset while addr 2 is presented, then a fresh drain
    exp_blen = 0;
    issue_start();
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    res = '{'{16'd500, 16'd6}, '{16'd77, 16'd8}};
    res1[0][0] = 16'd9;
    issue_start();
    wait_idle(0);

    // randomized transactions with backpressure, stray starts and occasional resets
    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < 2; i++)
        for (int j = 0; j < 2; j++) res[i][j] = rnd_elem();
      res1[0][0] = rnd_elem();
      rdy = ($urandom_range(0, 3) != 0);
      issue_start();
      if ($urandom_range(0, 5) == 0) begin
        int m = $urandom_range(0, 3);
        for (int c = 0; c < m; c++) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
      end
      wait_idle(1);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    repeat (3) begin @(posedge clk); #1; end
    end_req = 1;
    wait (end_ack);
    @(posedge clk); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
